// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles every signal between the shared-memory arbiter, its two requesters
// (instruction fetch and the data-memory stage) and the unified memory model.
//
// Signal groups:
//   fetch side  : if_req, if_addr        -> arbiter -> if_gnt, if_valid, if_rdata
//   data side   : dm_req, dm_we, dm_addr, dm_wdata
//                                        -> arbiter -> dm_gnt, dm_valid, dm_rdata
//   memory side : arbiter -> mem_en, mem_we, mem_addr, mem_wdata, mem_xfer_size
//                 memory  -> mem_rdata
//   pipeline    : arbiter -> stall_if, stall_mem
//
// Modports:
//   slave  : the arbiter itself
//   master : the environment (pipeline stages plus memory model)
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if;
    logic        if_req;
    logic [63:0] if_addr;
    logic        if_gnt;
    logic        if_valid;
    logic [31:0] if_rdata;

    logic        dm_req;
    logic        dm_we;
    logic [63:0] dm_addr;
    logic [63:0] dm_wdata;
    logic        dm_gnt;
    logic        dm_valid;
    logic [63:0] dm_rdata;

    logic        mem_en;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [3:0]  mem_xfer_size;
    logic [63:0] mem_rdata;

    logic        stall_if;
    logic        stall_mem;

    modport slave (
        input  if_req, if_addr,
        input  dm_req, dm_we, dm_addr, dm_wdata,
        input  mem_rdata,
        output if_gnt, if_valid, if_rdata,
        output dm_gnt, dm_valid, dm_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_xfer_size,
        output stall_if, stall_mem
    );

    modport master (
        output if_req, if_addr,
        output dm_req, dm_we, dm_addr, dm_wdata,
        output mem_rdata,
        input  if_gnt, if_valid, if_rdata,
        input  dm_gnt, dm_valid, dm_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_xfer_size,
        input  stall_if, stall_mem
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port memory between instruction fetch (IF) and the
// data-memory stage (DM). Arbitrates in IDLE, issues one transaction, waits a
// fixed MEM_LAT cycles for the response, then returns to IDLE.
//
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous, active-high reset
//   bus  : mem_port_arbiter_if.slave (requester, memory and stall signals)
//
// Parameters:
//   MEM_LAT    : cycles from issue (mem_en) to response, 1..15
//   STARVE_MAX : consecutive lost arbitrations IF tolerates while requesting
//                before it is forced to win, 1..15
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_port_arbiter_if.slave     bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } state_t;

    localparam logic [3:0] LAT_LOAD   = 4'(MEM_LAT - 1);
    localparam logic [3:0] STARVE_TOP = 4'(STARVE_MAX);
    localparam logic [3:0] SIZE_IF    = 4'b0100;
    localparam logic [3:0] SIZE_DM    = 4'b1000;

    state_t     state, state_nxt;
    logic [3:0] lat_cnt, lat_cnt_nxt;
    logic [3:0] starve_cnt, starve_cnt_nxt;
    logic       wr_flag, wr_flag_nxt;

    // DM holds the older instruction, so it wins by default; IF wins when it
    // is alone or when it has already lost STARVE_MAX arbitrations in a row.
    logic if_wins;
    logic dm_wins;
    assign if_wins = bus.if_req & (~bus.dm_req | (starve_cnt == STARVE_TOP));
    assign dm_wins = bus.dm_req & ~if_wins;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            lat_cnt    <= 4'd0;
            starve_cnt <= 4'd0;
            wr_flag    <= 1'b0;
        end else begin
            state      <= state_nxt;
            lat_cnt    <= lat_cnt_nxt;
            starve_cnt <= starve_cnt_nxt;
            wr_flag    <= wr_flag_nxt;
        end
    end

    // Reset forces every grant/response output to its idle value in the same
    // cycle, which also drops any response still in flight in the memory.
    always_comb begin
        state_nxt          = state;
        lat_cnt_nxt        = lat_cnt;
        starve_cnt_nxt     = starve_cnt;
        wr_flag_nxt        = wr_flag;
        bus.if_gnt         = 1'b0;
        bus.if_valid       = 1'b0;
        bus.if_rdata       = 32'd0;
        bus.dm_gnt         = 1'b0;
        bus.dm_valid       = 1'b0;
        bus.dm_rdata       = 64'd0;
        bus.mem_en         = 1'b0;
        bus.mem_we         = 1'b0;
        bus.mem_addr       = 64'd0;
        bus.mem_wdata      = 64'd0;
        bus.mem_xfer_size  = SIZE_DM;

        if (!rst) begin
            unique case (state)
                IDLE: begin
                    if (if_wins) begin
                        bus.if_gnt        = 1'b1;
                        bus.mem_en        = 1'b1;
                        bus.mem_addr      = bus.if_addr;
                        bus.mem_xfer_size = SIZE_IF;
                        state_nxt         = BUSY_IF;
                        lat_cnt_nxt       = LAT_LOAD;
                        wr_flag_nxt       = bus.dm_we;
                        starve_cnt_nxt    = 4'd0;
                    end else if (dm_wins) begin
                        bus.dm_gnt        = 1'b1;
                        bus.mem_en        = 1'b1;
                        bus.mem_we        = bus.dm_we;
                        bus.mem_addr      = bus.dm_addr;
                        bus.mem_wdata     = bus.dm_wdata;
                        bus.mem_xfer_size = SIZE_DM;
                        state_nxt         = BUSY_DM;
                        lat_cnt_nxt       = LAT_LOAD;
                        wr_flag_nxt       = bus.dm_we;
                        // IF only counts as starved if it was actually asking.
                        if (!bus.if_req) begin
                            starve_cnt_nxt = 4'd0;
                        end else if (starve_cnt != STARVE_TOP) begin
                            starve_cnt_nxt = starve_cnt + 4'd1;
                        end
                    end else begin
                        starve_cnt_nxt = 4'd0;
                    end
                end
                BUSY_IF: begin
                    if (lat_cnt == 4'd0) begin
                        bus.if_valid = 1'b1;
                        bus.if_rdata = bus.mem_rdata[31:0];
                        state_nxt    = IDLE;
                    end else begin
                        lat_cnt_nxt = lat_cnt - 4'd1;
                    end
                end
                BUSY_DM: begin
                    if (lat_cnt == 4'd0) begin
                        bus.dm_valid = 1'b1;
                        // A store acknowledge carries no data.
                        bus.dm_rdata = wr_flag ? 64'd0 : bus.mem_rdata;
                        state_nxt    = IDLE;
                    end else begin
                        lat_cnt_nxt = lat_cnt - 4'd1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end

        bus.stall_if  = bus.if_req & ~bus.if_valid;
        bus.stall_mem = bus.dm_req & ~bus.dm_valid;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Drives two arbiter instances (MEM_LAT=2/STARVE_MAX=4 and MEM_LAT=1/
// STARVE_MAX=1) with the same random request stream and compares every
// output each cycle against a transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int LAT0  = 2;
    localparam int SMAX0 = 4;
    localparam int LAT1  = 1;
    localparam int SMAX1 = 1;
    localparam int NUM_CYCLES = 3000;

    typedef struct {
        logic        if_gnt;
        logic        if_valid;
        logic [31:0] if_rdata;
        logic        dm_gnt;
        logic        dm_valid;
        logic [63:0] dm_rdata;
        logic        mem_en;
        logic        mem_we;
        logic [63:0] mem_addr;
        logic [63:0] mem_wdata;
        logic [3:0]  xfer;
        logic        stall_if;
        logic        stall_mem;
    } outs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    mem_port_arbiter_if bus0 ();
    mem_port_arbiter_if bus1 ();

    mem_port_arbiter #(.MEM_LAT(LAT0), .STARVE_MAX(SMAX0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    mem_port_arbiter #(.MEM_LAT(LAT1), .STARVE_MAX(SMAX1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // Shared requester stimulus
    logic        if_req_s   = 1'b0;
    logic        dm_req_s   = 1'b0;
    logic        dm_we_s    = 1'b0;
    logic [63:0] if_addr_s  = 64'd0;
    logic [63:0] dm_addr_s  = 64'd0;
    logic [63:0] dm_wdata_s = 64'd0;

    // Reference model state, one slot per DUT
    int          lat_of    [2];
    int          smax_of   [2];
    bit          m_busy    [2];
    bit          m_dm      [2];
    bit          m_store   [2];
    logic [63:0] m_addr    [2];
    int          m_gcyc    [2];
    int          m_starve  [2];

    // Memory model issue history (ring indexed by cycle)
    bit          iss_v [2][16];
    logic [63:0] iss_a [2][16];

    function automatic logic [63:0] mem_word(input logic [63:0] a);
        return {a[31:0] ^ 32'h5A5A_0F0F, ~a[31:0]};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got,
                               input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s cycle %0d got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [63:0] mem_response(input int k);
        int lat;
        int idx;
        lat = lat_of[k];
        idx = (cyc - lat) % 16;
        if (cyc >= lat && iss_v[k][idx])
            return mem_word(iss_a[k][idx]);
        return {$urandom, $urandom};
    endfunction

    task automatic applyStimulus(input bit do_rst);
        rst = do_rst;
        if ($urandom_range(0, 9) == 0) if_req_s = ~if_req_s;
        if ($urandom_range(0, 7) == 0) dm_req_s = ~dm_req_s;
        dm_we_s    = 1'($urandom_range(0, 1));
        if_addr_s  = {$urandom, $urandom};
        dm_addr_s  = {$urandom, $urandom};
        dm_wdata_s = {$urandom, $urandom};

        bus0.if_req   = if_req_s;
        bus0.if_addr  = if_addr_s;
        bus0.dm_req   = dm_req_s;
        bus0.dm_we    = dm_we_s;
        bus0.dm_addr  = dm_addr_s;
        bus0.dm_wdata = dm_wdata_s;
        bus0.mem_rdata = mem_response(0);

        bus1.if_req   = if_req_s;
        bus1.if_addr  = if_addr_s;
        bus1.dm_req   = dm_req_s;
        bus1.dm_we    = dm_we_s;
        bus1.dm_addr  = dm_addr_s;
        bus1.dm_wdata = dm_wdata_s;
        bus1.mem_rdata = mem_response(1);
    endtask

    function automatic outs_t sample(input int k);
        outs_t o;
        if (k == 0) begin
            o.if_gnt = bus0.if_gnt;     o.if_valid = bus0.if_valid;   o.if_rdata = bus0.if_rdata;
            o.dm_gnt = bus0.dm_gnt;     o.dm_valid = bus0.dm_valid;   o.dm_rdata = bus0.dm_rdata;
            o.mem_en = bus0.mem_en;     o.mem_we = bus0.mem_we;       o.mem_addr = bus0.mem_addr;
            o.mem_wdata = bus0.mem_wdata; o.xfer = bus0.mem_xfer_size;
            o.stall_if = bus0.stall_if; o.stall_mem = bus0.stall_mem;
        end else begin
            o.if_gnt = bus1.if_gnt;     o.if_valid = bus1.if_valid;   o.if_rdata = bus1.if_rdata;
            o.dm_gnt = bus1.dm_gnt;     o.dm_valid = bus1.dm_valid;   o.dm_rdata = bus1.dm_rdata;
            o.mem_en = bus1.mem_en;     o.mem_we = bus1.mem_we;       o.mem_addr = bus1.mem_addr;
            o.mem_wdata = bus1.mem_wdata; o.xfer = bus1.mem_xfer_size;
            o.stall_if = bus1.stall_if; o.stall_mem = bus1.stall_mem;
        end
        return o;
    endfunction

    // Transaction-level model: a transaction granted in cycle g responds in
    // cycle g+MEM_LAT; arbitration only while no transaction is outstanding.
    task automatic model_step(input int k, output outs_t e);
        logic [63:0] w;
        e = '{default: '0};
        e.xfer = 4'b1000;
        if (rst) begin
            m_busy[k]   = 1'b0;
            m_starve[k] = 0;
        end else if (m_busy[k]) begin
            if (cyc == m_gcyc[k] + lat_of[k]) begin
                m_busy[k] = 1'b0;
                w = mem_word(m_addr[k]);
                if (m_dm[k]) begin
                    e.dm_valid = 1'b1;
                    e.dm_rdata = m_store[k] ? 64'd0 : w;
                end else begin
                    e.if_valid = 1'b1;
                    e.if_rdata = w[31:0];
                end
            end
        end else if (if_req_s && (!dm_req_s || m_starve[k] == smax_of[k])) begin
            e.if_gnt    = 1'b1;
            e.mem_en    = 1'b1;
            e.mem_addr  = if_addr_s;
            e.xfer      = 4'b0100;
            m_busy[k]   = 1'b1;
            m_dm[k]     = 1'b0;
            m_addr[k]   = if_addr_s;
            m_gcyc[k]   = cyc;
            m_starve[k] = 0;
        end else if (dm_req_s) begin
            e.dm_gnt    = 1'b1;
            e.mem_en    = 1'b1;
            e.mem_we    = dm_we_s;
            e.mem_addr  = dm_addr_s;
            e.mem_wdata = dm_wdata_s;
            m_busy[k]   = 1'b1;
            m_dm[k]     = 1'b1;
            m_store[k]  = dm_we_s;
            m_addr[k]   = dm_addr_s;
            m_gcyc[k]   = cyc;
            if (!if_req_s)
                m_starve[k] = 0;
            else if (m_starve[k] < smax_of[k])
                m_starve[k] = m_starve[k] + 1;
        end else begin
            m_starve[k] = 0;
        end
        e.stall_if  = if_req_s & ~e.if_valid;
        e.stall_mem = dm_req_s & ~e.dm_valid;
    endtask

    task automatic compare_all(input int k, input outs_t g, input outs_t e);
        string p;
        p = $sformatf("dut%0d.", k);
        checkOutput({p, "if_gnt"},    64'(g.if_gnt),    64'(e.if_gnt));
        checkOutput({p, "if_valid"},  64'(g.if_valid),  64'(e.if_valid));
        checkOutput({p, "if_rdata"},  64'(g.if_rdata),  64'(e.if_rdata));
        checkOutput({p, "dm_gnt"},    64'(g.dm_gnt),    64'(e.dm_gnt));
        checkOutput({p, "dm_valid"},  64'(g.dm_valid),  64'(e.dm_valid));
        checkOutput({p, "dm_rdata"},  g.dm_rdata,       e.dm_rdata);
        checkOutput({p, "mem_en"},    64'(g.mem_en),    64'(e.mem_en));
        checkOutput({p, "mem_we"},    64'(g.mem_we),    64'(e.mem_we));
        checkOutput({p, "mem_addr"},  g.mem_addr,       e.mem_addr);
        checkOutput({p, "mem_wdata"}, g.mem_wdata,      e.mem_wdata);
        checkOutput({p, "xfer_size"}, 64'(g.xfer),      64'(e.xfer));
        checkOutput({p, "stall_if"},  64'(g.stall_if),  64'(e.stall_if));
        checkOutput({p, "stall_mem"}, 64'(g.stall_mem), 64'(e.stall_mem));
    endtask

    initial begin
        outs_t got;
        outs_t exp;
        lat_of[0] = LAT0;  smax_of[0] = SMAX0;
        lat_of[1] = LAT1;  smax_of[1] = SMAX1;
        for (int k = 0; k < 2; k++) begin
            m_busy[k]   = 1'b0;
            m_dm[k]     = 1'b0;
            m_store[k]  = 1'b0;
            m_addr[k]   = 64'd0;
            m_gcyc[k]   = 0;
            m_starve[k] = 0;
            for (int i = 0; i < 16; i++) begin
                iss_v[k][i] = 1'b0;
                iss_a[k][i] = 64'd0;
            end
        end

        $display("[TB] starting %0d cycles", NUM_CYCLES);
        for (int c = 0; c < NUM_CYCLES; c++) begin
            cyc = c;
            @(negedge clk);
            applyStimulus(c < 3 || $urandom_range(0, 49) == 0);
            #1;
            for (int k = 0; k < 2; k++) begin
                got = sample(k);
                model_step(k, exp);
                compare_all(k, got, exp);
                iss_v[k][c % 16] = (got.mem_en === 1'b1);
                iss_a[k][c % 16] = got.mem_addr;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
